// File: rtl/mul_pipe_pkg.sv
// rtl/mul_pipe_pkg.sv - shared muldiv operation encoding and operand helpers
package muldiv_types;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,
        MUL_HS  = 2'b01,
        MUL_HU  = 2'b10,
        MUL_HSU = 2'b11
    } mul_op_t;

    function automatic logic op_a_signed(input mul_op_t op);
        return (op == MUL_HS) || (op == MUL_HSU);
    endfunction

    function automatic logic op_b_signed(input mul_op_t op);
        return op == MUL_HS;
    endfunction

    function automatic logic op_high(input mul_op_t op);
        return op != MUL_LO;
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// rtl/mul_pipe_stage.sv - one valid/data pipeline slice with bubble-collapsing advance
module mul_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_adv_next,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_adv
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // An empty slot can always take new data, even if downstream is stalled.
    assign o_adv   = !r_valid || i_adv_next;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= 1'b0;
        end else if (o_adv) begin
            r_valid <= i_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (o_adv) begin
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/mul_pipe.sv
// rtl/mul_pipe.sv - parametrised pipelined multiplier with valid/ready, flush and tag
module mul_pipe
    import muldiv_types::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PW = 2 * WIDTH + 1 + TAG_W;

    mul_op_t          w_op;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [PW-1:0]      w_payload;
    logic [PW-1:0]      w_last_data;
    logic               w_last_valid;
    logic               w_adv0;

    assign w_op = mul_op_t'(in_op);

    // Extending straight to 2*WIDTH yields the same truncated product as a
    // WIDTH+1 extension, and keeps every multiplier output bit in use.
    assign w_a_ext   = {{WIDTH{op_a_signed(w_op) & in_a[WIDTH-1]}}, in_a};
    assign w_b_ext   = {{WIDTH{op_b_signed(w_op) & in_b[WIDTH-1]}}, in_b};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_payload = {w_prod, op_high(w_op), in_tag};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic          w_v_in;
        logic [PW-1:0] w_d_in;
        logic          w_adv_next;
        logic          w_v;
        logic [PW-1:0] w_d;
        logic          w_adv;

        if (k == 0) begin : g_head
            assign w_v_in = in_valid & in_ready;
            assign w_d_in = w_payload;
        end else begin : g_body
            assign w_v_in = g_stage[k-1].w_v;
            assign w_d_in = g_stage[k-1].w_d;
        end

        if (k == STAGES - 1) begin : g_tail
            assign w_adv_next = out_ready;
        end else begin : g_link
            assign w_adv_next = g_stage[k+1].w_adv;
        end

        mul_pipe_stage #(.W(PW)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .i_valid    (w_v_in),
            .i_data     (w_d_in),
            .i_adv_next (w_adv_next),
            .o_valid    (w_v),
            .o_data     (w_d),
            .o_adv      (w_adv)
        );
    end

    assign w_adv0       = g_stage[0].w_adv;
    assign w_last_valid = g_stage[STAGES-1].w_v;
    assign w_last_data  = g_stage[STAGES-1].w_d;

    assign in_ready   = w_adv0 & !flush;
    assign out_valid  = w_last_valid;
    assign out_tag    = w_last_data[TAG_W-1:0];
    assign out_result = w_last_data[TAG_W] ? w_last_data[TAG_W+1+WIDTH +: WIDTH]
                                           : w_last_data[TAG_W+1 +: WIDTH];

endmodule

// File: tb/tb_mul_pipe.sv
// tb/tb_mul_pipe.sv - directed vectors plus randomized parameter sweep for mul_pipe
module tb_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          cyc;
    } obs_t;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: interpret operands as integers, multiply exactly, pick a half.
    function automatic logic [63:0] ref_mul(input int w, input logic [1:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] av;
        logic signed [129:0] bv;
        logic signed [129:0] p;
        logic [129:0]        sh;
        logic [63:0]         mask;
        av = $signed({66'd0, a});
        bv = $signed({66'd0, b});
        if ((op == 2'd1 || op == 2'd3) && a[w-1]) av = av - (130'sd1 <<< w);
        if (op == 2'd1 && b[w-1]) bv = bv - (130'sd1 <<< w);
        p    = av * bv;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        sh   = (op == 2'd0) ? p : (p >> w);
        return sh[63:0] & mask;
    endfunction

    logic        d_rst, d_flush, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [1:0]  d_in_op;
    logic [31:0] d_in_a, d_in_b, d_out_result;
    logic [4:0]  d_in_tag, d_out_tag;

    mul_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) u_dut (
        .clk        (clk),
        .rst        (d_rst),
        .flush      (d_flush),
        .in_valid   (d_in_valid),
        .in_ready   (d_in_ready),
        .in_op      (d_in_op),
        .in_a       (d_in_a),
        .in_b       (d_in_b),
        .in_tag     (d_in_tag),
        .out_valid  (d_out_valid),
        .out_ready  (d_out_ready),
        .out_result (d_out_result),
        .out_tag    (d_out_tag)
    );

    obs_t obs[$];
    int   d_cyc;
    logic d_acc;

    // One clock: sample handshakes mid-cycle, then move to the next falling edge.
    task automatic d_step();
        obs_t o;
        #1;
        d_acc = d_in_valid && d_in_ready;
        if (d_out_valid && d_out_ready) begin
            o.res = d_out_result;
            o.tag = d_out_tag;
            o.cyc = d_cyc;
            obs.push_back(o);
        end
        @(negedge clk);
        d_cyc++;
    endtask

    localparam int SW_S[3] = '{1, 3, 4};
    localparam int SW_W[3] = '{16, 64, 16};

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int S = SW_S[g];
        localparam int W = SW_W[g];

        logic         rst, flush, in_valid, in_ready, out_valid, out_ready, done;
        logic [1:0]   op;
        logic [W-1:0] a, b, res;
        logic [4:0]   tag, otag, next_tag;
        logic [63:0]  r64;
        exp_t         q[$];
        exp_t         e;
        bit           stall;

        mul_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(5)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .in_op      (op),
            .in_a       (a),
            .in_b       (b),
            .in_tag     (tag),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .out_result (res),
            .out_tag    (otag)
        );

        initial begin
            done = 1'b0; rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
            op = 2'd0; a = '0; b = '0; tag = '0; next_tag = '0;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            for (int it = 0; it < 900; it++) begin
                stall    = (it >= 300) && (it < 850);
                in_valid = (it < 850) && ($urandom_range(0, 3) != 0);
                op       = 2'($urandom_range(0, 3));
                r64 = {$urandom(), $urandom()}; a = r64[W-1:0];
                r64 = {$urandom(), $urandom()}; b = r64[W-1:0];
                case ($urandom_range(0, 7))
                    0: a = '1;
                    1: a = {1'b1, {(W-1){1'b0}}};
                    2: b = '1;
                    3: b = {1'b1, {(W-1){1'b0}}};
                    default: ;
                endcase
                tag       = next_tag;
                out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                flush     = stall && ($urandom_range(0, 49) == 0);
                #1;
                if (!stall) chk($sformatf("sw%0d_ready", g), in_ready, 1);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk($sformatf("sw%0d_spurious", g), 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("sw%0d_result", g), 64'(res), e.res);
                        chk($sformatf("sw%0d_tag", g), otag, e.tag);
                        if (e.cyc + S < 300) chk($sformatf("sw%0d_latency", g), it - e.cyc, S);
                    end
                end
                if (flush) begin
                    q.delete();
                end else if (in_valid && in_ready) begin
                    e.res = ref_mul(W, op, 64'(a), 64'(b));
                    e.tag = tag;
                    e.cyc = it;
                    q.push_back(e);
                    next_tag = next_tag + 5'd1;
                end
                @(negedge clk);
            end
            chk($sformatf("sw%0d_drained", g), q.size(), 0);
            done = 1'b1;
        end
    end

    initial begin
        vec_t        tbl[6];
        int          acc_cyc[6];
        logic [1:0]  bp_op[4];
        logic [31:0] bp_a[4], bp_b[4];
        logic [31:0] held_res;
        logic [4:0]  held_tag;
        int          k;

        tbl[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        tbl[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[2] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[3] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[4] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        tbl[5] = '{2'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};

        d_rst = 1'b1; d_flush = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0;
        d_in_op = 2'd0; d_in_a = '0; d_in_b = '0; d_in_tag = '0; d_cyc = 0;
        repeat (3) @(negedge clk);
        d_rst = 1'b0;
        #1;
        chk("reset_out_valid", d_out_valid, 0);
        chk("reset_in_ready", d_in_ready, 1);
        @(negedge clk);

        // Back-to-back vectors with the consumer always ready.
        obs.delete();
        d_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d_in_valid = 1'b1; d_in_op = tbl[i].op; d_in_a = tbl[i].a; d_in_b = tbl[i].b;
            d_in_tag = 5'(i + 1);
            acc_cyc[i] = d_cyc;
            d_step();
            chk("tbl_accept", d_acc, 1);
        end
        d_in_valid = 1'b0;
        repeat (4) d_step();
        chk("tbl_count", obs.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < obs.size()) begin
                chk($sformatf("tbl%0d_result", i), obs[i].res, tbl[i].exp);
                chk($sformatf("tbl%0d_tag", i), obs[i].tag, 5'(i + 1));
            end
        end
        if (obs.size() > 0) chk("tbl_latency", obs[0].cyc - acc_cyc[0], 2);

        // Backpressure: two slots fill, output holds steady, then drains in order.
        obs.delete();
        for (int i = 0; i < 4; i++) begin
            bp_op[i] = 2'($urandom_range(0, 3)); bp_a[i] = $urandom(); bp_b[i] = $urandom();
        end
        d_out_ready = 1'b0;
        k = 0;
        held_res = '0; held_tag = '0;
        for (int s = 0; s < 5; s++) begin
            d_in_valid = (k < 4);
            d_in_op = bp_op[k % 4]; d_in_a = bp_a[k % 4]; d_in_b = bp_b[k % 4];
            d_in_tag = 5'(10 + k);
            d_step();
            if (d_acc) k++;
            if (s >= 1) begin
                chk("bp_in_ready_low", d_in_ready, 0);
                chk("bp_out_valid", d_out_valid, 1);
            end
            if (s == 1) begin
                held_res = d_out_result; held_tag = d_out_tag;
            end else if (s > 1) begin
                chk("bp_hold_result", d_out_result, held_res);
                chk("bp_hold_tag", d_out_tag, held_tag);
            end
        end
        chk("bp_accepted", k, 2);
        d_out_ready = 1'b1;
        for (int s = 0; s < 12; s++) begin
            d_in_valid = (k < 4);
            d_in_op = bp_op[k % 4]; d_in_a = bp_a[k % 4]; d_in_b = bp_b[k % 4];
            d_in_tag = 5'(10 + k);
            d_step();
            if (d_acc) k++;
        end
        d_in_valid = 1'b0;
        chk("bp_all_accepted", k, 4);
        chk("bp_count", obs.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < obs.size()) begin
                chk($sformatf("bp%0d_tag", i), obs[i].tag, 5'(10 + i));
                chk($sformatf("bp%0d_result", i), obs[i].res,
                    32'(ref_mul(32, bp_op[i], 64'(bp_a[i]), 64'(bp_b[i]))));
            end
        end

        // Flush with two operations in flight and a new one offered.
        obs.delete();
        d_out_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            d_in_valid = 1'b1; d_in_op = 2'd2; d_in_a = $urandom(); d_in_b = $urandom();
            d_in_tag = 5'(16 + s);
            d_step();
        end
        d_flush = 1'b1; d_in_valid = 1'b1;
        #1;
        chk("flush_in_ready", d_in_ready, 0);
        d_step();
        chk("flush_not_accepted", d_acc, 0);
        d_flush = 1'b0; d_out_ready = 1'b1;
        d_in_valid = 1'b1; d_in_op = 2'd0; d_in_a = 32'd3; d_in_b = 32'd5; d_in_tag = 5'd20;
        #1;
        chk("post_flush_ready", d_in_ready, 1);
        d_step();
        chk("post_flush_accept", d_acc, 1);
        d_in_valid = 1'b0;
        repeat (4) d_step();
        chk("flush_out_count", obs.size(), 1);
        if (obs.size() > 0) begin
            chk("flush_out_tag", obs[0].tag, 5'd20);
            chk("flush_out_result", obs[0].res, 32'd15);
        end

        // Reset (together with flush) while the pipeline is full.
        obs.delete();
        d_out_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            d_in_valid = 1'b1; d_in_op = 2'd0; d_in_a = $urandom(); d_in_b = $urandom();
            d_in_tag = 5'(24 + s);
            d_step();
        end
        d_in_valid = 1'b0; d_rst = 1'b1; d_flush = 1'b1;
        d_step();
        d_rst = 1'b0; d_flush = 1'b0;
        #1;
        chk("rst_out_valid", d_out_valid, 0);
        chk("rst_in_ready", d_in_ready, 1);
        d_out_ready = 1'b1;
        repeat (4) d_step();
        chk("rst_no_output", obs.size(), 0);

        for (int t = 0; t < 20000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done); t++)
            @(negedge clk);
        chk("sweep_done", g_sw[0].done && g_sw[1].done && g_sw[2].done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_pipe.md
# mul_pipe

Parametrised, fully pipelined integer multiplier for the execute stage. It generalises the fixed 32-bit single-cycle-register multiplier to configurable operand width, pipeline depth and tag width. It adds valid/ready backpressure, flush, and a signed×unsigned high-half mode. It sits beside the divider in the muldiv cluster and accepts one operation per cycle when not stalled.

## Interface
- WIDTH, 32, operand/result width in bits (≥8, even)
- STAGES, 2, register stages from accept to result valid (≥1)
- TAG_W, 5, width of opaque tag carried alongside each operation (e.g. ROB/dest id)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill all in-flight operations
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted this cycle when in_valid & in_ready
- in_op  in  2  mul_op_t: MUL_LO=00, MUL_HS=01, MUL_HU=10, MUL_HSU=11
- in_a  in  WIDTH  multiplicand (rs1)
- in_b  in  WIDTH  multiplier (rs2)
- in_tag  in  TAG_W  tag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result when out_valid & out_ready
- out_result  out  WIDTH  selected product half
- out_tag  out  TAG_W  tag of the result

## Operation
- Sign extension of operands to WIDTH+1 bits:
  - a is signed for HS and HSU.
  - b is signed for HS only.
  - LO uses unsigned extension; the low half is identical either way.
- Full product is 2·WIDTH+2 bits, truncated to 2·WIDTH.
- LO selects product[WIDTH-1:0]; HS, HU and HSU select product[2·WIDTH-1:WIDTH].
- Product is computed from the accepted operands and written into stage 0 together with the half-select, tag and valid. Stages 1..STAGES-1 carry product, select and tag unchanged; these are retiming slack for synthesis.
- Half selection is a mux on the last stage. out_result and out_tag are driven from the last stage only.
- Pipeline control is bubble-collapsing:
  - adv[k] = !v[k] | adv[k+1], with adv[STAGES-1] = !v[last] | out_ready.
  - in_ready = adv[0] & !flush.
- A stage register loads only when its adv is high. Otherwise it holds, so output data stays stable while out_valid & !out_ready.
- Flush:
  - all v[k] ← 0 at the next edge;
  - an input offered in the flush cycle is not accepted (in_ready low);
  - a result presented in the flush cycle may be taken by the consumer; the block does not retract it combinationally.
- Data registers are not reset; only the valid bits are.

## Timing
- Reset: all v[k] = 0, so out_valid = 0 and in_ready = 1 from the first cycle after reset (unless flush).
- Latency: an operation accepted at edge t gives out_valid = 1 in the cycle after edge t+STAGES-1, i.e. STAGES cycles. STAGES=1 reproduces the legacy one-cycle done.
- Throughput: 1 op/cycle while out_ready stays high.
- Backpressure with out_ready low:
  - the pipeline fills;
  - in_ready drops only when every stage is valid;
  - up to STAGES operations are held, with no loss or duplication.
- Simultaneous out handshake and in handshake with a full pipeline is legal: everything shifts one stage.
- Reset mid-operation: all in-flight ops are discarded and no out_valid is produced from them.
- Flush with rst: same result as rst.

## Structure
- Shared package muldiv_types:
  - mul_op_t enum;
  - helper functions op_a_signed(op), op_b_signed(op), op_high(op).
- The divider reuses these helpers.
- One sub-module, mul_pipe_stage: a valid/data register slice with the adv logic, parametrised on payload width and instantiated STAGES times via generate.
- The top level holds the extension, multiply and output mux.

## Test plan
- WIDTH=32, STAGES=2, a=b=0xFFFFFFFF, four ops back-to-back, out_ready=1:
  - results in order are 0x00000001, 0x00000000, 0xFFFFFFFE, 0xFFFFFFFF;
  - the first result is valid 2 cycles after accept;
  - tags match.
- HS with a=b=0x80000000 → 0x40000000. LO with a=0x12345678, b=0x10 → 0x23456780.
- Hold out_ready=0 and offer 4 ops:
  - exactly 2 are accepted, then in_ready=0;
  - out_result and out_tag stay stable;
  - raising out_ready drains both in order, and the remaining ops are then accepted.
- Assert flush with 2 ops in flight and in_valid=1:
  - in_ready=0 that cycle;
  - no out_valid follows;
  - the next op is accepted one cycle after flush.
- Assert rst while the pipeline is full → out_valid=0 the following cycle, and in_ready=1.
- Parameter sweep STAGES∈{1,3,4}, WIDTH∈{16,64}, with random ops, random stalls and a reference model:
  - results match the reference model;
  - latency equals STAGES when there is no stall.
